// File: rtl/ps2_kbd_port_if.sv
// CPU/PS2-side signal bundle for the memory-mapped keyboard port.
// The master drives the PS/2 byte strobe and CPU bus; the slave is the port itself.
interface ps2_kbd_port_if;
    logic [7:0]  PS2_DATA;
    logic        PS2_HIT;
    logic [15:0] ADDR;
    logic [7:0]  DATA_WR;
    logic        WREN;
    logic [7:0]  DATA_RD;
    logic        SEL;
    logic        IRQ;

    modport master (
        output PS2_DATA, PS2_HIT, ADDR, DATA_WR, WREN,
        input  DATA_RD, SEL, IRQ
    );

    modport slave (
        input  PS2_DATA, PS2_HIT, ADDR, DATA_WR, WREN,
        output DATA_RD, SEL, IRQ
    );
endinterface

// File: rtl/ps2_kbd_port.sv
// Keyboard port: decodes PS/2 scancode prefixes into key events, queues them in a
// FIFO, tracks modifier keys, and exposes everything as four CPU-polled registers.
module ps2_kbd_port #(
    parameter logic [15:0] BASE       = 16'hFFA0,
    parameter int          DEPTH_LOG2 = 4
) (
    input logic          CLOCK,
    input logic          RESET,
    ps2_kbd_port_if.slave bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0] ONE_COUNT  = {{DEPTH_LOG2{1'b0}}, 1'b1};

    typedef enum logic [2:0] {IDLE, EXT, BRK, EXTBRK, SKIP} dec_state_t;

    dec_state_t state_q, state_d;
    logic [2:0] skip_q, skip_d;
    logic       emit, emit_brk, emit_ext;
    logic [9:0] entry;

    logic [9:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  ovf_q, ovf_d;
    logic [4:0]            mods_q, mods_d;
    logic                  irq_q;

    logic [15:0] offset;
    logic        sel, empty, full;
    logic        pop_req, flush, clr_ovf, do_pop, do_push;
    logic [9:0]  head;
    logic [7:0]  data_rd;

    // Prefix decoder: E0 marks extended, F0 marks break, E1 starts the 8-byte Pause run.
    always_comb begin
        state_d  = state_q;
        skip_d   = skip_q;
        emit     = 1'b0;
        emit_brk = 1'b0;
        emit_ext = 1'b0;
        if (bus.PS2_HIT) begin
            case (state_q)
                IDLE: begin
                    if (bus.PS2_DATA == 8'hE0)      state_d = EXT;
                    else if (bus.PS2_DATA == 8'hF0) state_d = BRK;
                    else if (bus.PS2_DATA == 8'hE1) begin
                        state_d = SKIP;
                        skip_d  = 3'd7;
                    end else                        emit = 1'b1;
                end
                EXT: begin
                    if (bus.PS2_DATA == 8'hF0) state_d = EXTBRK;
                    else if (bus.PS2_DATA != 8'hE0 && bus.PS2_DATA != 8'hE1) begin
                        emit     = 1'b1;
                        emit_ext = 1'b1;
                        state_d  = IDLE;
                    end
                end
                BRK: begin
                    emit     = 1'b1;
                    emit_brk = 1'b1;
                    state_d  = IDLE;
                end
                EXTBRK: begin
                    emit     = 1'b1;
                    emit_brk = 1'b1;
                    emit_ext = 1'b1;
                    state_d  = IDLE;
                end
                SKIP: begin
                    skip_d = skip_q - 3'd1;
                    if (skip_q <= 3'd1) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign entry = {emit_ext, emit_brk, bus.PS2_DATA};

    assign offset  = bus.ADDR - BASE;
    assign sel     = offset < 16'd4;
    assign empty   = count_q == '0;
    assign full    = count_q == FULL_COUNT;
    assign pop_req = bus.WREN && sel && offset[1:0] == 2'd0;
    assign clr_ovf = bus.WREN && sel && offset[1:0] == 2'd1 && bus.DATA_WR[6];
    assign flush   = bus.WREN && sel && offset[1:0] == 2'd2;
    // Flush beats everything; a full FIFO only accepts a push when a pop frees the slot.
    assign do_pop  = pop_req && !empty && !flush;
    assign do_push = emit && !flush && (!full || do_pop);

    always_comb begin
        count_d = count_q;
        if (flush)                 count_d = '0;
        else if (do_push && !do_pop) count_d = count_q + ONE_COUNT;
        else if (do_pop && !do_push) count_d = count_q - ONE_COUNT;

        ovf_d = ovf_q;
        if (flush || clr_ovf) ovf_d = 1'b0;
        if (emit && full && !do_pop && !flush) ovf_d = 1'b1;

        mods_d = mods_q;
        if (emit) begin
            case (bus.PS2_DATA)
                8'h12:   if (!emit_ext) mods_d[0] = !emit_brk;
                8'h59:   mods_d[1] = !emit_brk;
                8'h14:   mods_d[2] = !emit_brk;
                8'h11:   mods_d[3] = !emit_brk;
                8'h58:   if (!emit_brk) mods_d[4] = !mods_q[4];
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q <= IDLE;
            skip_q  <= 3'd0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            mods_q  <= 5'd0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            skip_q  <= skip_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            mods_q  <= mods_d;
            irq_q   <= count_d != '0;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (do_push) wr_ptr <= wr_ptr + 1'b1;
                if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge CLOCK) begin
        if (do_push) mem[wr_ptr] <= entry;
    end

    assign head = mem[rd_ptr];

    always_comb begin
        data_rd = 8'h00;
        if (sel) begin
            case (offset[1:0])
                2'd0:    data_rd = empty ? 8'h00 : head[7:0];
                2'd1:    data_rd = {!empty, ovf_q, 4'b0000,
                                    !empty && head[9], !empty && head[8]};
                2'd2:    data_rd = {{(7 - DEPTH_LOG2){1'b0}}, count_q};
                default: data_rd = {3'b000, mods_q};
            endcase
        end
    end

    assign bus.DATA_RD = data_rd;
    assign bus.SEL     = sel;
    assign bus.IRQ     = irq_q;
endmodule
